lsu_decode_buf: RTL and testbench

- Address decoder for the LSU of the single-cycle RISC-V core.
- Turns each LSU address and write-enable into same-cycle write enables for the SDRAM (data memory) buffer and the output-peripheral buffer.
- Also registers a read-region select for the LSU read-data mux, since memory reads return data one cycle later.
- Flags writes to unmapped or read-only addresses with a sticky error bit.

---
 rtl/lsu_map_pkg.sv | 34 +++
 rtl/lsu_region_cmp.sv | 48 ++++
 rtl/lsu_decode_buf.sv | 69 ++++++
 tb/tb_lsu_decode_buf.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lsu_map_pkg.sv
// -----------------------------------------------------------------------------
// lsu_map_pkg
// Shared LSU memory-map definitions: region base/mask constants for the low
// 16 address bits, the 2-bit region code used as the read-data mux select,
// and a small helper that tests an address against one base/mask pair.
// -----------------------------------------------------------------------------
package lsu_map_pkg;

  // Region code; the numeric values are the read-data mux select encoding.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    SDRAM = 2'd1,
    OUTP  = 2'd2,
    INP   = 2'd3
  } region_e;

  // SDRAM: 0x2000-0x3FFF (addr[15:13] = 3'b001)
  localparam logic [15:0] SDRAM_BASE = 16'h2000;
  localparam logic [15:0] SDRAM_MASK = 16'hE000;
  // Output peripheral: 0x7000-0x77FF (addr[15:11] = 5'b01110)
  localparam logic [15:0] OUTP_BASE  = 16'h7000;
  localparam logic [15:0] OUTP_MASK  = 16'hF800;
  // Input peripheral (read-only): 0x7800-0x7FFF (addr[15:11] = 5'b01111)
  localparam logic [15:0] INP_BASE   = 16'h7800;
  localparam logic [15:0] INP_MASK   = 16'hF800;

  // True when the masked low address bits equal the region base.
  function automatic logic in_region(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/lsu_region_cmp.sv
// -----------------------------------------------------------------------------
// lsu_region_cmp
// Pure combinational address-to-region decoder with full decode: any nonzero
// bit above bit 15 makes the address unmapped.
// Ports:
//   addr_i   : LSU byte address (ADDR_W bits, ADDR_W >= 16)
//   region_o : decoded region code (NONE when unmapped)
// -----------------------------------------------------------------------------
module lsu_region_cmp
  import lsu_map_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output region_e           region_o
);

  logic        upper_zero_s;
  logic [15:0] low_s;

  assign low_s = addr_i[15:0];

  // With a 16-bit address there are no upper bits to check.
  generate
    if (ADDR_W > 16) begin : g_upper
      assign upper_zero_s = ~|addr_i[ADDR_W-1:16];
    end else begin : g_no_upper
      assign upper_zero_s = 1'b1;
    end
  endgenerate

  // Region priority is irrelevant (regions are disjoint); chain kept for clarity.
  always_comb begin
    region_o = NONE;
    if (!upper_zero_s) begin
      region_o = NONE;
    end else if (in_region(low_s, SDRAM_BASE, SDRAM_MASK)) begin
      region_o = SDRAM;
    end else if (in_region(low_s, OUTP_BASE, OUTP_MASK)) begin
      region_o = OUTP;
    end else if (in_region(low_s, INP_BASE, INP_MASK)) begin
      region_o = INP;
    end else begin
      region_o = NONE;
    end
  end

endmodule

// File: rtl/lsu_decode_buf.sv
// -----------------------------------------------------------------------------
// lsu_decode_buf
// LSU address decoder for the single-cycle core. Produces same-cycle write
// enables for the SDRAM and output-peripheral buffers, a registered read
// region select (memory reads return one cycle later), and a sticky error
// flag for writes to unmapped or read-only addresses.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_lsu_addr     : LSU byte address
//   i_lsu_wren     : LSU write request
//   sdram_buf_en   : combinational SDRAM buffer write enable
//   output_buf_en  : combinational output buffer write enable
//   o_rd_sel       : previous cycle's region code (read-data mux select)
//   o_wr_err       : sticky faulting-write flag, cleared only by reset
// -----------------------------------------------------------------------------
module lsu_decode_buf
  import lsu_map_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic              i_lsu_wren,
  output logic              output_buf_en,
  output logic              sdram_buf_en,
  output logic [1:0]        o_rd_sel,
  output logic              o_wr_err
);

  region_e region_s;
  region_e rd_sel_q, rd_sel_d;
  logic    wr_err_q, wr_err_d;
  logic    fault_s;

  lsu_region_cmp #(
    .ADDR_W (ADDR_W)
  ) u_region_cmp (
    .addr_i   (i_lsu_addr),
    .region_o (region_s)
  );

  // Enables are gated by wren first so an unknown address cannot raise them
  // on a read cycle; they are mutually exclusive because regions are.
  assign sdram_buf_en  = i_lsu_wren & (region_s == SDRAM);
  assign output_buf_en = i_lsu_wren & (region_s == OUTP);

  // Next-state for the read select and the sticky write-error flag.
  always_comb begin
    fault_s  = i_lsu_wren & ((region_s == NONE) | (region_s == INP));
    rd_sel_d = region_s;
    wr_err_d = wr_err_q | fault_s;
  end

  // State registers; reset overrides a faulting write in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_sel_q <= NONE;
      wr_err_q <= 1'b0;
    end else begin
      rd_sel_q <= rd_sel_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign o_rd_sel = rd_sel_q;
  assign o_wr_err = wr_err_q;

endmodule

// File: tb/tb_lsu_decode_buf.sv
// -----------------------------------------------------------------------------
// tb_lsu_decode_buf
// Self-checking bench: a behavioural memory-map model (address ranges in plain
// arithmetic) is compared against the DUT every cycle, with directed cycles
// that also pin literal expectations, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_lsu_decode_buf;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        wren;
  logic        output_buf_en;
  logic        sdram_buf_en;
  logic [1:0]  o_rd_sel;
  logic        o_wr_err;

  int checks = 0;
  int errors = 0;

  // Model state: what the registered outputs must show this cycle.
  int m_rd  = 0;
  int m_err = 0;

  lsu_decode_buf #(.ADDR_W(32)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_lsu_addr    (addr),
    .i_lsu_wren    (wren),
    .output_buf_en (output_buf_en),
    .sdram_buf_en  (sdram_buf_en),
    .o_rd_sel      (o_rd_sel),
    .o_wr_err      (o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region by address range: 1=SDRAM, 2=output, 3=input, 0=unmapped.
  function automatic int ref_region(input logic [31:0] a);
    if (a >= 32'h0000_2000 && a < 32'h0000_4000) return 1;
    if (a >= 32'h0000_7000 && a < 32'h0000_7800) return 2;
    if (a >= 32'h0000_7800 && a < 32'h0000_8000) return 3;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (addr=%h wren=%0d t=%0t)",
               name, act, exp, addr, wren, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare mid-cycle against the model (and
  // optional literal expectations, -1 = none), then advance the model at the edge.
  task automatic cyc(input logic [31:0] a, input logic w, input logic r,
                     input int l_sd, input int l_op, input int l_rd, input int l_err);
    int reg_now;
    addr = a;
    wren = w;
    rst  = r;
    @(negedge clk);
    reg_now = ref_region(a);
    chk("sdram_buf_en",  int'(sdram_buf_en),  (w && reg_now == 1) ? 1 : 0);
    chk("output_buf_en", int'(output_buf_en), (w && reg_now == 2) ? 1 : 0);
    chk("o_rd_sel",      int'(o_rd_sel),      m_rd);
    chk("o_wr_err",      int'(o_wr_err),      m_err);
    if (l_sd  >= 0) chk("lit_sdram_en", int'(sdram_buf_en),  l_sd);
    if (l_op  >= 0) chk("lit_out_en",   int'(output_buf_en), l_op);
    if (l_rd  >= 0) chk("lit_rd_sel",   int'(o_rd_sel),      l_rd);
    if (l_err >= 0) chk("lit_wr_err",   int'(o_wr_err),      l_err);
    @(posedge clk);
    if (r) begin
      m_rd  = 0;
      m_err = 0;
    end else begin
      m_rd = reg_now;
      if (w && (reg_now == 0 || reg_now == 3)) m_err = 1;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = 32'h0000_2000 + $urandom_range(0, 32'h1FFF);
      1:       a = 32'h0000_7000 + $urandom_range(0, 32'h07FF);
      2:       a = 32'h0000_7800 + $urandom_range(0, 32'h07FF);
      3:       a = $urandom & 32'h0000_FFFF;
      4:       a = $urandom;
      default: begin
        case ($urandom_range(0, 7))
          0:       a = 32'h0000_1FFF;
          1:       a = 32'h0000_3FFF;
          2:       a = 32'h0000_4000;
          3:       a = 32'h0000_6FFF;
          4:       a = 32'h0000_77FF;
          5:       a = 32'h0000_7FFF;
          6:       a = 32'h0000_8000;
          default: a = 32'h0001_2000;
        endcase
      end
    endcase
    return a;
  endfunction

  initial begin
    addr = 32'h0;
    wren = 1'b0;
    rst  = 1'b1;

    // Reset then idle
    cyc(32'h0000_0000, 1'b0, 1'b1, 0, 0, -1, -1);
    cyc(32'h0000_0000, 1'b0, 1'b1, 0, 0, 0, 0);
    // SDRAM writes
    cyc(32'h0000_201F, 1'b1, 1'b0, 1, 0, 0, 0);
    cyc(32'h0000_30F0, 1'b1, 1'b0, 1, 0, 1, 0);
    // Output writes
    cyc(32'h0000_7000, 1'b1, 1'b0, 0, 1, 1, 0);
    cyc(32'h0000_7010, 1'b1, 1'b0, 0, 1, 2, 0);
    cyc(32'h0000_70F0, 1'b1, 1'b0, 0, 1, 2, 0);
    // Unmapped writes set the sticky error
    cyc(32'h0000_6000, 1'b1, 1'b0, 0, 0, 2, 0);
    cyc(32'h0000_4000, 1'b1, 1'b0, 0, 0, 0, 1);
    cyc(32'h0000_F000, 1'b1, 1'b0, 0, 0, 0, 1);
    // Reads are not writes
    cyc(32'h0000_30F0, 1'b0, 1'b0, 0, 0, 0, 1);
    cyc(32'h0000_7800, 1'b0, 1'b0, 0, 0, 1, 1);
    cyc(32'h0000_0000, 1'b0, 1'b0, 0, 0, 3, 1);
    // Reset clears the error
    cyc(32'h0000_0000, 1'b0, 1'b1, 0, 0, 0, 1);
    // Upper-bit and boundary checks
    cyc(32'h0001_2000, 1'b1, 1'b0, 0, 0, 0, 0);
    cyc(32'h0000_1FFF, 1'b1, 1'b0, 0, 0, 0, 1);
    cyc(32'h0000_0000, 1'b0, 1'b1, 0, 0, 0, 1);
    cyc(32'h0000_3FFF, 1'b1, 1'b0, 1, 0, 0, 0);
    cyc(32'h0000_77FF, 1'b1, 1'b0, 0, 1, 1, 0);
    cyc(32'h0000_7800, 1'b1, 1'b0, 0, 0, 2, 0);
    cyc(32'h0000_0000, 1'b0, 1'b0, 0, 0, 3, 1);
    // Reset wins over a simultaneous faulting write
    cyc(32'h0000_6000, 1'b1, 1'b1, 0, 0, 0, 1);
    cyc(32'h0000_0000, 1'b0, 1'b0, 0, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(rand_addr(), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, -1, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
